// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: scoreboard entry type and forward-select helpers shared by the hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W_MAX = 8;
  localparam int FW_RF = 0;
  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dest;
    logic                 load;
  } sb_entry_t;
  function automatic int fw_width(input int depth);
    return depth < 1 ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/branch/memory inputs and hazard-control outputs of the pipeline controller
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3
);
  localparam int FW = pipe_ctrl_pkg::fw_width(DEPTH);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_wr;
  logic             id_load;
  logic             br_taken;
  logic             mem_busy;
  logic             stall;
  logic             freeze;
  logic             flush;
  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic [15:0]      stall_cnt;
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wr, id_load, br_taken, mem_busy,
    input  stall, freeze, flush, fwd_a, fwd_b, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wr, id_load, br_taken, mem_busy,
    output stall, freeze, flush, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_sb_match.sv
// pipe_sb_match: youngest-match priority encoder over the scoreboard for one source register
module pipe_sb_match
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int DEPTH = 3
) (
  input  sb_entry_t [DEPTH-1:0]           sb,
  input  logic      [REG_W-1:0]           src,
  input  logic                            use_src,
  output logic      [fw_width(DEPTH)-1:0] sel,
  output logic                            ld
);
  localparam int FW = fw_width(DEPTH);
  always_comb begin
    sel = FW'(FW_RF);
    ld = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (use_src && src != '0 && sb[k].valid && sb[k].dest == REG_W_MAX'(src)) begin
        sel = FW'(k + 1);
        ld = sb[k].load;
      end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard forwarding select, load-use stall, memory freeze and branch flush control
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 2
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int FW = fw_width(DEPTH);
  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  sb_entry_t             id_e;
  logic                  pending_flush_q, pending_flush_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic [FW-1:0]         sel_a, sel_b;
  logic                  ld_a, ld_b, haz_a, haz_b, load_use, freeze, flush, stall;
  pipe_sb_match #(.REG_W(REG_W), .DEPTH(DEPTH)) u_match_rs (
    .sb(sb_q), .src(bus.id_rs), .use_src(bus.id_use_rs), .sel(sel_a), .ld(ld_a)
  );
  pipe_sb_match #(.REG_W(REG_W), .DEPTH(DEPTH)) u_match_rt (
    .sb(sb_q), .src(bus.id_rt), .use_src(bus.id_use_rt), .sel(sel_b), .ld(ld_b)
  );
  always_comb begin
    haz_a = ld_a && sel_a != FW'(FW_RF) && int'(sel_a) <= LOAD_LAT;
    haz_b = ld_b && sel_b != FW'(FW_RF) && int'(sel_b) <= LOAD_LAT;
    load_use = bus.id_valid && (haz_a || haz_b);
    freeze = bus.mem_busy;
    flush = !freeze && (bus.br_taken || pending_flush_q);
    stall = freeze || (load_use && !flush);
    id_e = (bus.id_valid && bus.id_wr && !stall && !flush) ?
           sb_entry_t'{valid: 1'b1, dest: REG_W_MAX'(bus.id_dest), load: bus.id_load} : '0;
    sb_d = sb_q;
    sb_d[0] = freeze ? sb_q[0] : id_e;
    for (int k = 1; k < DEPTH; k++)
      sb_d[k] = freeze ? sb_q[k] : (flush && k - 1 < BR_STAGE) ? '0 : sb_q[k-1];
    pending_flush_d = freeze && (pending_flush_q || bus.br_taken);
    stall_cnt_d = stall_cnt_q + 16'(load_use && !flush && !freeze && stall_cnt_q != 16'hFFFF);
  end
  assign bus.freeze    = freeze;
  assign bus.flush     = flush;
  assign bus.stall     = stall;
  assign bus.fwd_a     = haz_a ? FW'(FW_RF) : sel_a;
  assign bus.fwd_b     = haz_b ? FW'(FW_RF) : sel_b;
  assign bus.stall_cnt = stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
      pending_flush_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      pending_flush_q <= pending_flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter REG_W, default 5: register-index width.
REQ-003 Parameter DEPTH, default 3: number of in-flight stages tracked beyond decode (EX..WB).
REQ-004 Parameter LOAD_LAT, default 1: the load result is forwardable only from slot index >= LOAD_LAT.
REQ-005 Parameter BR_STAGE, default 2: slot index at which a branch resolves; must be < DEPTH.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: reset  in  1  synchronous active-high reset.
REQ-008 Port: id_valid  in  1  decode holds a valid instruction.
REQ-009 Port: id_rs, id_rt  in  REG_W each  source registers.
REQ-010 Port: id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-011 Port: id_dest  in  REG_W  destination register.
REQ-012 Port: id_wr, id_load  in  1 each  instruction writes dest / is a load.
REQ-013 Port: br_taken  in  1  branch at slot BR_STAGE taken (one-cycle pulse).
REQ-014 Port: mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-015 Port: stall  out  1  hold PC and IF/ID, inject a bubble (PCWrite = !stall).
REQ-016 Port: freeze  out  1  hold every pipeline register.
REQ-017 Port: flush  out  1  kill IF/ID and slots 0..BR_STAGE-1.
REQ-018 Port: fwd_a, fwd_b  out  FW=$clog2(DEPTH+1)  0 = register file, k+1 = slot k.
REQ-019 Port: stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-020 Scoreboard: DEPTH slots of {valid, dest, load}; slot 0 = EX.
REQ-021 An instruction writes a scoreboard slot only when its id_wr=1; id_wr=0 inserts valid=0 in the slot.
REQ-022 Every non-frozen cycle the scoreboard SHALL shift: slot k -> k+1, the last slot retires, slot 0 <= decode entry, or a bubble if !id_valid, stall or flush.
REQ-023 A match on rs requires id_use_rs, slot valid, dest == id_rs and id_rs != 0; the same rule applies to rt.
REQ-024 fwd_a/fwd_b SHALL select the lowest-index matching slot k (the youngest); the output is k+1, or 0 on no match. Outputs are combinational from the registered state.
REQ-025 If the selected slot holds a load with k < LOAD_LAT, the block SHALL raise stall=1 (load-use) and drive fwd=0.
REQ-026 freeze = mem_busy, combinational; while freeze=1: scoreboard, pending_flush and stall_cnt hold, and stall=1.
REQ-027 br_taken with freeze=0: flush=1 the same cycle; on that edge slots 0..BR_STAGE-1 are cleared before the shift and the decode entry becomes a bubble.
REQ-028 br_taken with freeze=1: set pending_flush; flush=1 on the first cycle with freeze=0, then clear pending_flush.
REQ-029 flush SHALL have priority over a load-use stall: when flush=1, stall=0 unless freeze=1.
REQ-030 stall_cnt SHALL increment by 1 per load-use stall cycle (not freeze cycles) and saturate at 16'hFFFF.
REQ-031 No instruction SHALL be issued or duplicated while stall=1 or freeze=1.

Reset
REQ-032 On a clk edge with reset=1, all slots SHALL become invalid, and pending_flush and stall_cnt SHALL be set to 0.
REQ-033 After reset: stall=0, flush=0, fwd_a=fwd_b=0; freeze SHALL track mem_busy.
REQ-034 Reset asserted mid-freeze or mid-pending flush SHALL discard the pending state with no flush pulse afterwards.

Structure
REQ-035 A shared package pipe_ctrl_pkg SHALL hold the scoreboard entry struct, the FW_RF=0 constant and the fwd-select width function.
REQ-036 One sub-module, pipe_sb_match, SHALL be used: a DEPTH-wide youngest-match priority encoder, instanced for rs and for rt.

Verification
REQ-037 ADD r3 then ADD r4,r3,r1 on consecutive cycles -> fwd_a=1, stall=0; with one NOP between -> fwd_a=2.
REQ-038 LW r5 then ADD r6,r5,r2 -> stall=1 for 1 cycle, stall_cnt=1, then fwd_a=2.
REQ-039 A writer to r0 followed by a reader of r0 -> fwd=0, stall=0.
REQ-040 br_taken pulse with 3 valid slots -> flush=1 for 1 cycle; slots 0,1 invalid, slot 2 retires normally.
REQ-041 mem_busy=1 for 4 cycles with br_taken in cycle 2 -> freeze=1 for 4 cycles, scoreboard unchanged, flush=1 exactly in cycle 5.
REQ-042 Force stall_cnt to 16'hFFFE, then apply 3 load-use stalls -> stall_cnt=16'hFFFF; reset -> stall_cnt=0.
